// File: rtl/microsequencer.sv
// Next-state engine of the microcoded controller: it drives the ROM address (state),
// decodes the returned opcode, and sequences through increment, dispatch, wait and restart.
module microsequencer #(
  parameter logic [3:0] ACCEPT_STATE = 4'd12,
  parameter logic [1:0] MATCH_TOKEN  = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] microinstruction,
  input  logic [1:0] in_token,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       tbl_we,
  input  logic       tbl_sel,
  input  logic [1:0] tbl_addr,
  input  logic [3:0] tbl_wdata,
  output logic [3:0] state,
  output logic       accept,
  output logic       err,
  output logic [7:0] step_count
);

  typedef enum logic [3:0] {
    OP_INC     = 4'd0,
    OP_DISP1   = 4'd1,
    OP_DISP2   = 4'd2,
    OP_WAIT    = 4'd3,
    OP_RESTART = 4'd4
  } opcode_e;

  logic [3:0] disp1 [4];
  logic [3:0] disp2 [4];

  logic       token_op;
  logic       illegal_op;
  logic       advance;
  logic [3:0] next_state;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = 4'd0;
    token_op   = 1'b0;
    illegal_op = 1'b0;
    case (microinstruction)
      OP_INC:     next_state = state + 4'd1;
      OP_DISP1: begin
        token_op   = 1'b1;
        next_state = disp1[in_token];
      end
      OP_DISP2: begin
        token_op   = 1'b1;
        next_state = disp2[in_token];
      end
      OP_WAIT: begin
        token_op   = 1'b1;
        next_state = (in_token == MATCH_TOKEN) ? state + 4'd1 : 4'd0;
      end
      OP_RESTART: next_state = 4'd0;
      default:    illegal_op = 1'b1;
    endcase
  end

  assign in_ready = run & ~reset & token_op;
  // Token opcodes advance only on a completed handshake; all others advance whenever run is high.
  assign advance  = run & (~token_op | (in_valid & in_ready));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= 4'd0;
      accept     <= 1'b0;
      err        <= 1'b0;
      step_count <= 8'd0;
      // NOTE: the dispatch tables are reset explicitly because their reset contents are functional defaults.
      for (int k = 0; k < 4; k++) begin
        disp1[k] <= 4'(4 + k);
        disp2[k] <= 4'(8 + k);
      end
    end else begin
      // Writes land at the edge, so a same-cycle dispatch still reads the old entry.
      if (tbl_we) begin
        if (tbl_sel) disp2[tbl_addr] <= tbl_wdata;
        else         disp1[tbl_addr] <= tbl_wdata;
      end
      if (run) begin
        accept <= advance && (next_state == ACCEPT_STATE);
        if (advance) begin
          state <= next_state;
          if (step_count != 8'hFF) step_count <= step_count + 8'd1;
          if (illegal_op) err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer; inputs change and outputs are
// sampled 1 time unit after each rising edge, well away from the next edge.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset, run, in_valid, tbl_we, tbl_sel;
  logic [3:0] microinstruction, tbl_wdata;
  logic [1:0] in_token, tbl_addr;
  logic       in_ready, accept, err;
  logic [3:0] state;
  logic [7:0] step_count;

  int n_cmp = 0;
  int n_err = 0;

  microsequencer #(.ACCEPT_STATE(4'd12), .MATCH_TOKEN(2'd3)) dut (
    .clk(clk), .reset(reset), .run(run), .microinstruction(microinstruction),
    .in_token(in_token), .in_valid(in_valid), .in_ready(in_ready),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .state(state), .accept(accept), .err(err), .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [3:0] st, input logic [7:0] cnt,
                            input logic acc, input logic er);
    check({tag, ".state"}, 16'(state), 16'(st));
    check({tag, ".count"}, 16'(step_count), 16'(cnt));
    check({tag, ".accept"}, 16'(accept), 16'(acc));
    check({tag, ".err"}, 16'(err), 16'(er));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; microinstruction = 4'd0; in_token = 2'd0; in_valid = 1'b0;
    tbl_we = 1'b0; tbl_sel = 1'b0; tbl_addr = 2'd0; tbl_wdata = 4'd0;
    tick(); tick();
    check_regs("reset", 4'd0, 8'd0, 1'b0, 1'b0);
    // Ready must stay low while reset is asserted, even on a token opcode.
    run = 1'b1; microinstruction = 4'd1; #1;
    check("ready_in_reset", 16'(in_ready), 16'd0);
    tick();

    // INC x3 from reset
    reset = 1'b0; microinstruction = 4'd0; #1;
    check("inc_ready", 16'(in_ready), 16'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("inc_state", 16'(state), 16'(i));
      check("inc_ready_n", 16'(in_ready), 16'd0);
    end
    check("inc_count", 16'(step_count), 16'd3);

    // DISP1 stall then transfer with token 2 -> disp1[2] = 6
    microinstruction = 4'd1; in_token = 2'd2; in_valid = 1'b0; #1;
    check("disp_ready", 16'(in_ready), 16'd1);
    tick(); check_regs("disp_stall1", 4'd3, 8'd3, 1'b0, 1'b0);
    tick(); check_regs("disp_stall2", 4'd3, 8'd3, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick(); check_regs("disp1_go", 4'd6, 8'd4, 1'b0, 1'b0);

    // DISP2 token 1 with a simultaneous write of disp2[1]=12 -> old value 9
    microinstruction = 4'd2; in_token = 2'd1;
    tbl_we = 1'b1; tbl_sel = 1'b1; tbl_addr = 2'd1; tbl_wdata = 4'd12;
    tick(); check_regs("disp2_old", 4'd9, 8'd5, 1'b0, 1'b0);
    tbl_we = 1'b0;
    tick(); check_regs("disp2_new", 4'd12, 8'd6, 1'b1, 1'b0);
    microinstruction = 4'd0; in_valid = 1'b0;
    tick(); check_regs("accept_pulse_end", 4'd13, 8'd7, 1'b0, 1'b0);

    // WAIT at state 5 (reached via disp1[1]=5), match then mismatch
    microinstruction = 4'd1; in_token = 2'd1; in_valid = 1'b1;
    tick(); check("to5", 16'(state), 16'd5);
    microinstruction = 4'd3; in_token = 2'd3; #1;
    check("wait_ready", 16'(in_ready), 16'd1);
    tick(); check_regs("wait_match", 4'd6, 8'd9, 1'b0, 1'b0);
    microinstruction = 4'd1; in_token = 2'd1;
    tick(); check("to5b", 16'(state), 16'd5);
    microinstruction = 4'd3; in_token = 2'd0;
    tick(); check_regs("wait_miss", 4'd0, 8'd11, 1'b0, 1'b0);

    // Illegal opcode sets sticky err
    microinstruction = 4'd7; in_valid = 1'b0; #1;
    check("illegal_ready", 16'(in_ready), 16'd0);
    tick(); check_regs("illegal", 4'd0, 8'd12, 1'b0, 1'b1);
    microinstruction = 4'd0;
    tick(); check_regs("err_sticky", 4'd1, 8'd13, 1'b0, 1'b1);
    microinstruction = 4'd4;
    tick(); check_regs("restart", 4'd0, 8'd14, 1'b0, 1'b1);

    // run=0 freezes state, count and a live accept pulse
    microinstruction = 4'd2; in_token = 2'd1; in_valid = 1'b1;
    tick(); check_regs("reaccept", 4'd12, 8'd15, 1'b1, 1'b1);
    run = 1'b0; #1;
    check("frozen_ready", 16'(in_ready), 16'd0);
    tick(); check_regs("frozen1", 4'd12, 8'd15, 1'b1, 1'b1);
    tick(); check_regs("frozen2", 4'd12, 8'd15, 1'b1, 1'b1);
    run = 1'b1; microinstruction = 4'd0; in_valid = 1'b0;
    tick(); check_regs("resume", 4'd13, 8'd16, 1'b0, 1'b1);

    // Reset while a DISP1 token is offered: not consumed, tables restored
    microinstruction = 4'd1; in_token = 2'd2; in_valid = 1'b1; reset = 1'b1; #1;
    check("reset_wait_ready", 16'(in_ready), 16'd0);
    tick(); check_regs("reset_wait", 4'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0; microinstruction = 4'd2; in_token = 2'd1;
    tick(); check_regs("tbl_restored", 4'd9, 8'd1, 1'b0, 1'b0);

    // Long INC run: wrap at 15->0 and saturation of step_count at 255
    microinstruction = 4'd0; in_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 7)   check("wrap", 16'(state), 16'd0);
      if (i == 253) check("count254", 16'(step_count), 16'd254);
      if (i == 254) check("count255", 16'(step_count), 16'd255);
    end
    check_regs("saturate", 4'd5, 8'd255, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
